bk_pipe_subtractor: RTL and testbench
=====================================

// Module: bk_pipe_subtractor
// PURPOSE
//  Pipelined WIDTH-bit subtractor: diff = a - b - bin, built on the team's Brent-Kung
//  prefix tree (ppa_pre / ao21 / xor2 cells). Inverse operation of the combinational
//  16-bit Brent-Kung adder. Sits between operand issue and result writeback.
//  Uses a 3-stage valid/ready pipeline and emits borrow, signed-overflow and zero flags.
// PARAMETERS
//  WIDTH   16  operand/result width; power of two, >= 4
//  TAG_W   4   width of the opaque tag carried alongside each operation
// PORTS
//  clk        in   1        rising-edge clock, sole clock
//  rst_n      in   1        reset, synchronous, active-low
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept operand beat this cycle
//  in_a       in   WIDTH    minuend
//  in_b       in   WIDTH    subtrahend
//  in_bin     in   1        borrow in (1 = subtract one more)
//  in_tag     in   TAG_W    opaque tag, returned unchanged with result
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts result this cycle
//  out_diff   out  WIDTH    (a - b - bin) mod 2^WIDTH
//  out_bout   out  1        borrow out: 1 iff unsigned a < b + bin
//  out_ovf    out  1        signed overflow: sign(a)!=sign(b) && sign(diff)!=sign(a)
//  out_zero   out  1        1 iff out_diff == 0
//  out_tag    out  TAG_W    tag of the result beat
// BEHAVIOUR
//  Arithmetic: a + ~b + cin, cin = ~bin; bout = ~carry_out. All widths exact, no sign-ext.
//  Stage S1: register p=a^~b, g=a&~b, g_lsb=cin, a MSB, b MSB, tag, valid.
//  Stage S2: Brent-Kung up-sweep (log2 WIDTH levels of group P/G), registered.
//  Stage S3: down-sweep, post xor (sum = p ^ carry), flags; S3 regs drive out_*.
//  Latency: 3 cycles from in_valid&&in_ready to out_valid, when no stall.
//  Throughput: one op per cycle with out_ready held high.
//  Handshake: adv = ~out_valid | out_ready; in_ready = adv (combinational, no other inputs).
//   - adv=1: all stages shift one step; S1 loads in_* with valid = in_valid.
//   - adv=0: every stage holds; in_* ignored. Bubbles are not collapsed.
//   - out_* stable while out_valid && !out_ready; in_valid may drop without affecting held data.
//  Reset (rst_n=0 at clk edge): all stage valids=0, all data/flag regs=0; so out_valid=0,
//   out_diff=0, out_bout=0, out_ovf=0, out_zero=0, out_tag=0; in_ready=1 in the next cycle.
//   Reset mid-operation discards every in-flight op; nothing emerges after reset.
//  Simultaneous accept+emit on same cycle is legal and loses nothing.
//  Boundaries: a==b, bin=0 -> diff 0, zero=1, bout=0; a==b, bin=1 -> all-ones, bout=1;
//   0 - 0 - 1 -> all-ones, bout=1, ovf=0; min-signed - 1 -> max-signed, ovf=1.
//  No internal state beyond pipeline regs; no FSM other than per-stage valid bits.
// TESTING
//  5-0x0003-0 (a=0x0005) -> 3 cycles later diff=0x0002, bout=0, ovf=0, zero=0
//  a=0x0000,b=0x0001,bin=0 -> diff=0xFFFF, bout=1, ovf=0; a=0x1234,b=0x1234,bin=1 -> 0xFFFF, bout=1
//  a=0x8000,b=0x0001 -> diff=0x7FFF, ovf=1, bout=0; a=0x7FFF,b=0xFFFF -> 0x8000, ovf=1, bout=1
//  Back-to-back 8 ops, tags 0..7, out_ready low cycles 4-6 -> in_ready low same cycles, results in
//   order, tags 0..7, none lost or duplicated, out_* stable while stalled
//  Reset asserted with 3 ops in flight -> next cycle out_valid=0, all outputs 0, no stale result later
//  Random 10k ops vs reference model (a-b-bin, flags), random in_valid/out_ready -> zero mismatches

Source files
------------

// File: rtl/bk_pipe_subtractor_if.sv
// Operand-issue and result-writeback channels of the pipelined Brent-Kung subtractor.
// The issuing side uses the master modport; the subtractor uses the slave modport.
interface bk_pipe_subtractor_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_bin, in_tag, out_ready,
        input  in_ready, out_valid, out_diff, out_bout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bin, in_tag, out_ready,
        output in_ready, out_valid, out_diff, out_bout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/bk_pipe_subtractor.sv
// Three-stage valid/ready subtractor diff = a - b - bin, computed as a + ~b + ~bin
// through a Brent-Kung prefix tree split into up-sweep (S2) and down-sweep (S3).
module bk_pipe_subtractor #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bk_pipe_subtractor_if.slave  bus
);
    localparam int LEVELS = $clog2(WIDTH);

    // Group-generate combine: g_hi | (p_hi & g_lo).
    function automatic logic ao21(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

    logic             adv;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_cin;
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_g;
    logic             s2_cin;
    logic             s2_a_msb;
    logic             s2_b_msb;
    logic [TAG_W-1:0] s2_tag;

    logic             s3_valid;
    logic [WIDTH-1:0] s3_diff;
    logic             s3_bout;
    logic             s3_ovf;
    logic             s3_zero;
    logic [TAG_W-1:0] s3_tag;

    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] pre_g;
    logic [WIDTH-1:0] up_g;
    logic [WIDTH-1:0] up_p;
    logic [WIDTH-1:0] dn_g;
    logic             grp_p;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // A full output register is the only thing that can stall the pipe.
    assign adv          = ~s3_valid | bus.out_ready;
    assign bus.in_ready = adv;

    assign nb    = ~bus.in_b;
    assign pre_p = bus.in_a ^ nb;
    assign pre_g = bus.in_a & nb;

    // Up-sweep. The carry-in is folded into bit 0 so every span ending at bit 0
    // already holds the true carry into the next bit.
    // NOTE: always_comb assigns every output first, so no path can infer a latch.
    always_comb begin
        up_g    = s1_g;
        up_p    = s1_p;
        up_g[0] = ao21(s1_p[0], s1_cin, s1_g[0]);
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
                up_g[i] = ao21(up_p[i], up_g[i - (1 << l)], up_g[i]);
                up_p[i] = up_p[i] & up_p[i - (1 << l)];
            end
        end
    end

    // Down-sweep fills the remaining prefixes. Each node's group propagate is
    // regenerated from the registered bit propagates rather than carried in S2.
    always_comb begin
        dn_g  = s2_g;
        grp_p = 1'b1;
        for (int l = LEVELS - 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
                grp_p = 1'b1;
                for (int j = 0; j < (1 << l); j++) begin
                    grp_p = grp_p & s2_p[i - j];
                end
                dn_g[i] = ao21(grp_p, dn_g[i - (1 << l)], dn_g[i]);
            end
        end
        sum  = s2_p ^ {dn_g[WIDTH-2:0], s2_cin};
        cout = dn_g[WIDTH-1];
        ovf  = (s2_a_msb ^ s2_b_msb) & (sum[WIDTH-1] ^ s2_a_msb);
    end

    // NOTE: sequential state uses <= so every stage samples the pre-edge value of its upstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared along with the valids so outputs read 0 after reset.
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_g     <= '0;
            s2_cin   <= 1'b0;
            s2_a_msb <= 1'b0;
            s2_b_msb <= 1'b0;
            s2_tag   <= '0;
            s3_valid <= 1'b0;
            s3_diff  <= '0;
            s3_bout  <= 1'b0;
            s3_ovf   <= 1'b0;
            s3_zero  <= 1'b0;
            s3_tag   <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_p     <= pre_p;
            s1_g     <= pre_g;
            s1_cin   <= ~bus.in_bin;
            s1_a_msb <= bus.in_a[WIDTH-1];
            s1_b_msb <= bus.in_b[WIDTH-1];
            s1_tag   <= bus.in_tag;

            s2_valid <= s1_valid;
            s2_p     <= s1_p;
            s2_g     <= up_g;
            s2_cin   <= s1_cin;
            s2_a_msb <= s1_a_msb;
            s2_b_msb <= s1_b_msb;
            s2_tag   <= s1_tag;

            s3_valid <= s2_valid;
            s3_diff  <= sum;
            s3_bout  <= ~cout;
            s3_ovf   <= ovf;
            s3_zero  <= (sum == '0);
            s3_tag   <= s2_tag;
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.out_diff  = s3_diff;
    assign bus.out_bout  = s3_bout;
    assign bus.out_ovf   = s3_ovf;
    assign bus.out_zero  = s3_zero;
    assign bus.out_tag   = s3_tag;
endmodule

// File: tb/tb_bk_pipe_subtractor.sv
// Scoreboard bench for bk_pipe_subtractor: stimulus pushes expected results from an
// arithmetic reference model; an independent monitor pops and compares every output beat.
module tb_bk_pipe_subtractor;
    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int N_RANDOM = 10000;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        logic             zero;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bk_pipe_subtractor_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    bk_pipe_subtractor #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin, input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint ia, ib, d;
        ia      = longint'(a);
        ib      = longint'(b);
        d       = ia - ib - longint'(bin);
        e.diff  = d[WIDTH-1:0];
        e.bout  = (ia < ib + longint'(bin));
        e.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
        e.zero  = (e.diff == '0);
        e.tag   = tag;
        e.cyc   = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_operand();
        logic [WIDTH-1:0] pool [5];
        pool = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
        if ($urandom_range(0, 7) == 0) return pool[$urandom_range(0, 4)];
        return WIDTH'($urandom);
    endfunction

    // One clock of stimulus: drive at the falling edge, then decide whether the
    // coming rising edge accepts the beat.
    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, input logic [TAG_W-1:0] tag, input bit ordy,
                         input bit lat, output bit acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_bin    = bin;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        #1;
        acc = v && (bus.in_ready === 1'b1);
        if (acc) begin
            e         = model(a, b, bin, tag);
            e.cyc     = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [TAG_W-1:0] tag, input bit lat);
        bit acc;
        int k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 50) begin
            drive(1'b1, a, b, bin, tag, 1'b1, lat, acc);
            k++;
        end
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input string name);
        bit acc;
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
            k++;
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares each transferred beat and holds stalled outputs steady.
    exp_t                     mon_e;
    logic [WIDTH+TAG_W+3:0]   cur;
    logic [WIDTH+TAG_W+3:0]   held;
    bit                       stalled = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst_n !== 1'b1) begin
            stalled = 1'b0;
        end else begin
            cur = {bus.out_valid, bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero, bus.out_tag};
            if (stalled) check("stall_stable", 64'(cur), 64'(held));
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: tag 0x%0h diff 0x%0h with no op outstanding",
                             bus.out_tag, bus.out_diff);
                end else begin
                    mon_e = sb.pop_front();
                    check("diff", 64'(bus.out_diff), 64'(mon_e.diff));
                    check("flags_bout_ovf_zero", 64'({bus.out_bout, bus.out_ovf, bus.out_zero}),
                          64'({mon_e.bout, mon_e.ovf, mon_e.zero}));
                    check("tag", 64'(bus.out_tag), 64'(mon_e.tag));
                    if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.cyc), 64'd3);
                end
                stalled = 1'b0;
            end else if (bus.out_valid === 1'b1) begin
                stalled = 1'b1;
                held    = cur;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_out_diff"},  64'(bus.out_diff),  64'd0);
        check({name, "_out_flags"}, 64'({bus.out_bout, bus.out_ovf, bus.out_zero}), 64'd0);
        check({name, "_out_tag"},   64'(bus.out_tag),   64'd0);
        check({name, "_in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    logic [WIDTH-1:0] dir_a   [7] = '{16'h0005, 16'h0000, 16'h1234, 16'h1234, 16'h8000, 16'h7FFF, 16'h0000};
    logic [WIDTH-1:0] dir_b   [7] = '{16'h0003, 16'h0001, 16'h1234, 16'h1234, 16'h0001, 16'hFFFF, 16'h0000};
    logic             dir_bin [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] st_a    [8];
    logic [WIDTH-1:0] st_b    [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               acc;
        bit               pending;
        int               idx;
        int               n_sent;
        int               budget;
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;
        logic [TAG_W-1:0] rtag;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_bin    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundary cases, back to back, latency checked.
        for (int i = 0; i < 7; i++) send(dir_a[i], dir_b[i], dir_bin[i], TAG_W'(i), 1'b1);
        drain("directed");

        // Eight ops with tags 0..7 while out_ready drops in cycles 4..6.
        for (int i = 0; i < 8; i++) begin
            st_a[i] = rnd_operand();
            st_b[i] = rnd_operand();
        end
        idx = 0;
        for (int i = 0; i < 40 && (idx < 8 || sb.size() != 0); i++) begin
            drive(idx < 8, st_a[idx % 8], st_b[idx % 8], 1'(idx % 2), TAG_W'(idx),
                  !(i >= 4 && i <= 6), 1'b0, acc);
            if (i < 8) check("stall_in_ready", 64'(bus.in_ready), 64'(!(i >= 4 && i <= 6)));
            if (acc) idx++;
        end
        check("stall_all_issued", 64'(idx), 64'd8);
        drain("stall");

        // Reset with three ops in flight: they must vanish.
        for (int k = 0; k < 3; k++) drive(1'b1, rnd_operand(), rnd_operand(), 1'b0, TAG_W'(k + 9), 1'b1, 1'b0, acc);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);

        // Randomised traffic with random in_valid and out_ready.
        pending = 1'b0;
        n_sent  = 0;
        budget  = 0;
        ra = '0; rb = '0; rbin = 1'b0; rtag = '0;
        while (n_sent < N_RANDOM && budget < 60000) begin
            if (!pending) begin
                ra      = rnd_operand();
                rb      = ($urandom_range(0, 15) == 0) ? ra : rnd_operand();
                rbin    = 1'($urandom_range(0, 1));
                rtag    = TAG_W'($urandom);
                pending = 1'b1;
            end
            drive($urandom_range(0, 9) < 7, ra, rb, rbin, rtag, $urandom_range(0, 9) < 7, 1'b0, acc);
            if (acc) begin
                pending = 1'b0;
                n_sent++;
            end
            budget++;
        end
        check("random_ops_issued", 64'(n_sent), 64'(N_RANDOM));
        drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
